// File: rtl/fetch_if.sv
// Fetch-stage bus: pipeline control in, instruction memory port, IF/ID
// register contents and status out.
interface fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  // Side that drives control and memory data (pipeline / environment)
  modport master (
    output stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, if_pc, if_instr, if_valid, halted, fetch_count
  );

  // Side implemented by the fetch unit
  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, if_pc, if_instr, if_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register, halt detection with
// a drain window so downstream stages can retire before fetch stops for good.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter logic [31:0] HALT_INSTR   = 32'h00000063,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // PC is word aligned by construction, also for an unaligned RESET_PC
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [3:0]  DRAIN_INIT       = 4'(DRAIN_CYCLES);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] if_instr_r, if_instr_s;
  logic        if_valid_r, if_valid_s;
  logic [31:0] count_r, count_s;
  logic [3:0]  drain_r, drain_s;

  // Next-state and next-register values; everything holds unless changed
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    if_pc_s    = if_pc_r;
    if_instr_s = if_instr_r;
    if_valid_s = if_valid_r;
    count_s    = count_r;
    drain_s    = drain_r;
    case (state_r)
      ST_RUN, ST_DRAIN: begin
        if (bus.redirect_valid) begin
          // Redirect beats stall and cancels any pending halt drain
          state_s    = ST_RUN;
          pc_s       = {bus.redirect_pc[31:2], 2'b00};
          if_pc_s    = bus.redirect_pc;
          if_instr_s = NOP_INSTR;
          if_valid_s = 1'b0;
          drain_s    = 4'd0;
        end else if (bus.stall) begin
          state_s = state_r;
        end else if (state_r == ST_RUN) begin
          if_pc_s    = pc_r;
          if_instr_s = bus.imem_instr;
          if_valid_s = 1'b1;
          count_s    = count_r + 32'd1;
          if (bus.imem_instr == HALT_INSTR) begin
            // Halt goes down the pipe once; PC parks on it
            state_s = ST_DRAIN;
            drain_s = DRAIN_INIT;
          end else begin
            pc_s = pc_r + 32'd4;
          end
        end else begin
          // Drain: feed bubbles until the window has elapsed
          if_pc_s    = pc_r;
          if_instr_s = NOP_INSTR;
          if_valid_s = 1'b0;
          if (drain_r == 4'd0) begin
            state_s = ST_HALTED;
          end else begin
            drain_s = drain_r - 4'd1;
          end
        end
      end
      ST_HALTED: begin
        if_pc_s    = pc_r;
        if_instr_s = NOP_INSTR;
        if_valid_s = 1'b0;
      end
      default: begin
        // Unreachable encoding: stop fetching rather than run wild
        state_s    = ST_HALTED;
        if_pc_s    = pc_r;
        if_instr_s = NOP_INSTR;
        if_valid_s = 1'b0;
        drain_s    = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC_ALIGNED;
      if_pc_r    <= RESET_PC;
      if_instr_r <= NOP_INSTR;
      if_valid_r <= 1'b0;
      count_r    <= 32'd0;
      drain_r    <= 4'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      if_pc_r    <= if_pc_s;
      if_instr_r <= if_instr_s;
      if_valid_r <= if_valid_s;
      count_r    <= count_s;
      drain_r    <= drain_s;
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.if_pc       = if_pc_r;
  assign bus.if_instr    = if_instr_r;
  assign bus.if_valid    = if_valid_r;
  assign bus.halted      = (state_r == ST_HALTED);
  assign bus.fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main flow plus
// hand-written sequences for reset-in-halt, halt/redirect races and PC wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fetch_if bus ();

  logic [31:0] mem [0:63];
  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } vec_t;

  vec_t vecs [0:20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] ipc,
                         input logic [31:0] instr, input logic valid, input logic halted,
                         input logic [31:0] count);
    chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".if_pc"}, bus.if_pc, ipc);
    chk({tag, ".if_instr"}, bus.if_instr, instr);
    chk({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, valid});
    chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, halted});
    chk({tag, ".fetch_count"}, bus.fetch_count, count);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 + 32'(i);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h00200193;
    mem[3] = 32'h00000063;

    //          stall rv    rpc            addr           if_pc          instr          v     h     cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h04,        32'h00,        32'h00500093,  1'b1, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h08,        32'h04,        32'h00100113,  1'b1, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h08,        32'h04,        32'h00100113,  1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h08,        32'h04,        32'h00100113,  1'b1, 1'b0, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h08,        32'h04,        32'h00100113,  1'b1, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h08,        32'h00200193,  1'b1, 1'b0, 32'd3};
    vecs[6]  = '{1'b1, 1'b1, 32'h43,       32'h40,        32'h43,        32'h00000013,  1'b0, 1'b0, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h44,        32'h40,        32'h10000010,  1'b1, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b1, 32'h0C,       32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b0, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000063,  1'b1, 1'b0, 32'd5};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000063,  1'b1, 1'b0, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b0, 32'd5};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b0, 32'd5};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b0, 32'd5};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};
    vecs[16] = '{1'b1, 1'b1, 32'h20,       32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};
    vecs[17] = '{1'b0, 1'b1, 32'h20,       32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};
    vecs[19] = '{1'b1, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        32'h0C,        32'h0C,        32'h00000013,  1'b0, 1'b1, 32'd5};

    // Reset, with noise on the other inputs
    drive(1'b1, 1'b1, 32'h80);
    rst = 1'b1;
    tick();
    tick();
    chk_all("reset", 32'h0, 32'h0, 32'h00000013, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Main flow: fetch, stall, redirect, halt with stalled drain, frozen halt
    for (int i = 0; i <= 20; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ipc, vecs[i].instr,
              vecs[i].valid, vecs[i].halted, vecs[i].count);
    end

    // Reset while HALTED overrides redirect and stall
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h20);
    tick();
    chk_all("rst_halted", 32'h0, 32'h0, 32'h00000013, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_all("refetch0", 32'h04, 32'h00, 32'h00500093, 1'b1, 1'b0, 32'd1);
    tick();
    tick();
    chk_all("at_halt", 32'h0C, 32'h08, 32'h00200193, 1'b1, 1'b0, 32'd3);

    // Redirect in the same cycle the halt word is presented: no drain
    drive(1'b0, 1'b1, 32'h20);
    tick();
    chk_all("halt_race", 32'h20, 32'h20, 32'h00000013, 1'b0, 1'b0, 32'd3);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_all("race_resume", 32'h24, 32'h20, 32'h10000008, 1'b1, 1'b0, 32'd4);

    // Halt latched, redirect two cycles later cancels the drain
    drive(1'b0, 1'b1, 32'h0C);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_all("halt2", 32'h0C, 32'h0C, 32'h00000063, 1'b1, 1'b0, 32'd5);
    tick();
    chk_all("bubble2", 32'h0C, 32'h0C, 32'h00000013, 1'b0, 1'b0, 32'd5);
    drive(1'b0, 1'b1, 32'h20);
    tick();
    chk_all("drain_redir", 32'h20, 32'h20, 32'h00000013, 1'b0, 1'b0, 32'd5);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_all("drain_resume", 32'h24, 32'h20, 32'h10000008, 1'b1, 1'b0, 32'd6);
    for (int i = 0; i < 6; i++) tick();
    chk_all("still_run", 32'h3C, 32'h38, 32'h1000000E, 1'b1, 1'b0, 32'd12);

    // PC wraps from 0xFFFFFFFC to 0
    drive(1'b0, 1'b1, 32'hFFFFFFFC);
    tick();
    chk_all("wrap_redir", 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000013, 1'b0, 1'b0, 32'd12);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_all("wrap", 32'h0, 32'hFFFFFFFC, 32'h1000003F, 1'b1, 1'b0, 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
